block_dispatcher: RTL and testbench
===================================

Name: block_dispatcher

Overview:
Kernel-level dispatcher that consumes the thread count held in the device control register. On kernel start it splits thread_count into blocks of THREADS_PER_BLOCK and hands block IDs to idle compute cores. It reclaims each core when the core reports completion. It raises done once every block has retired.

Parameters:
NUM_CORES, 2, number of compute cores served (1..8)
THREADS_PER_BLOCK, 4, maximum threads per block (power of two, 1..8)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  kernel start level from host; held high for the whole kernel
thread_count  input  8  total threads, from device control register
core_done  input  NUM_CORES  per-core block-complete flag (level)
core_start  output  NUM_CORES  per-core run request
core_reset  output  NUM_CORES  per-core reset; high = core free/idle
core_block_id  output  NUM_CORES*8  per-core block ID; slice i = [8*i+7:8*i]
core_thread_count  output  NUM_CORES*TC_W  per-core active threads; TC_W = $clog2(THREADS_PER_BLOCK+1)
done  output  1  kernel complete

Behaviour:
- Reset (synchronous, any state including mid-kernel) takes effect on the next edge. Afterwards:
  - state=IDLE; counters cleared.
  - core_reset all 1; core_start all 0.
  - core_block_id 0; core_thread_count 0; done 0.
- total_blocks = (thread_count + THREADS_PER_BLOCK - 1) / THREADS_PER_BLOCK, computed at 9 bits (no overflow at 255). It is latched on IDLE->RUN; later changes to thread_count are ignored until the next IDLE.
- A 9-bit remaining thread count is latched as well, for last-block sizing.
- Internal 9-bit counters: blocks_dispatched, blocks_done.
- States: IDLE, RUN, DONE (registered FSM).
- IDLE:
  - start=1, thread_count=0 -> DONE (done=1 on the next edge); no core is ever started.
  - start=1, thread_count>0 -> RUN; latch totals.
- RUN, dispatch (at most one per cycle):
  - Condition: blocks_dispatched < total_blocks.
  - Target: the lowest-index core with core_reset[i]=1.
  - Next edge, for that core: core_reset[i]<=0, core_start[i]<=1, core_block_id[i]<=blocks_dispatched[7:0], core_thread_count[i]<=min(THREADS_PER_BLOCK, thread_count_latched - blocks_dispatched*THREADS_PER_BLOCK).
  - blocks_dispatched increments.
- RUN, retire:
  - Any core with core_start[i]=1 and core_done[i]=1 -> next edge core_start[i]<=0, core_reset[i]<=1.
  - blocks_done increments by the number of such cores in that cycle (popcount, multiple same-cycle retires allowed).
  - core_done[i] is ignored while core_start[i]=0.
- A retired core holds core_reset=1 for at least one full cycle before re-dispatch. Re-dispatch to the same core is never in the same cycle as its retire.
- Dispatch to core j and retire of core i≠j in the same cycle are both performed.
- RUN -> DONE when blocks_done == total_blocks (evaluated on the registered counter). On that edge done<=1 and all core_reset<=1, core_start<=0.
- DONE: done held 1 while start=1. When start=0 -> IDLE, done<=0 on the next edge. core_block_id and core_thread_count keep their last values.
- start dropping during RUN is ignored; the kernel runs to completion, then DONE exits immediately since start=0.
- Latency: start sampled high at edge E (IDLE) -> RUN at E+1 -> first core_start at E+2. Final core_done sampled at edge F -> done at F+2: F+1 updates blocks_done, F+2 makes the transition.

Test Plan:
1. Reset check: assert reset 2 cycles with random inputs -> core_reset=all 1, core_start=0, done=0, block IDs and thread counts 0.
2. NUM_CORES=2, TPB=4, thread_count=8, start=1 -> core0 started with block 0, count 4 at E+2; core1 started with block 1, count 4 at E+3. Raise both core_done -> done=1 two edges later, all core_reset=1.
3. thread_count=10 -> blocks 0 and 1 dispatched with count 4. core0 done -> core0 reset for ≥1 cycle, then re-dispatched with block 2, count 2. After all dones, done=1 and total dispatched=3.
4. thread_count=0, start=1 -> done=1 at E+2 with no core_start pulse. Drop start -> done=0 next edge, state IDLE.
5. thread_count=255, TPB=4, both cores finishing in the same cycle repeatedly -> 64 blocks dispatched; final block count 3; blocks_done steps by 2; done asserted exactly once.
6. Reset asserted mid-RUN with core_start=2'b11 -> next edge all outputs at reset values. A new start then redispatches from block 0.

Source files
------------

// File: rtl/block_dispatcher.sv
// rtl/block_dispatcher.sv - kernel block dispatcher: splits thread_count into blocks and
// hands them to idle compute cores, reclaiming each core on completion.
module block_dispatcher #(
   parameter int NUM_CORES         = 2,
   parameter int THREADS_PER_BLOCK = 4,
   localparam int TC_W             = $clog2(THREADS_PER_BLOCK + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [7:0]                thread_count,
   input  logic [NUM_CORES-1:0]      core_done,
   output logic [NUM_CORES-1:0]      core_start,
   output logic [NUM_CORES-1:0]      core_reset,
   output logic [NUM_CORES*8-1:0]    core_block_id,
   output logic [NUM_CORES*TC_W-1:0] core_thread_count,
   output logic                      done
);

   localparam int TPB_SH = $clog2(THREADS_PER_BLOCK);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_next;

   logic [8:0]           total_blocks;
   logic [8:0]           remaining;
   logic [8:0]           blocks_dispatched;
   logic [8:0]           blocks_done;
   logic [8:0]           total_calc;
   logic [NUM_CORES-1:0] dispatch_sel;
   logic [NUM_CORES-1:0] retire;
   logic [8:0]           retire_count;
   logic                 found;
   logic                 dispatch_ok;
   logic [TC_W-1:0]      blk_threads;

   assign total_calc  = ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> TPB_SH;
   assign blk_threads = (remaining > 9'(THREADS_PER_BLOCK)) ? TC_W'(THREADS_PER_BLOCK)
                                                            : remaining[TC_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (thread_count == 8'd0) ? DONE : RUN;
         RUN:  if (blocks_done == total_blocks) state_next = DONE;
         DONE: if (!start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Lowest free core wins; a retiring core only becomes free after its core_reset registers.
   always_comb begin
      dispatch_sel = '0;
      found        = 1'b0;
      retire_count = 9'd0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (core_reset[i] && !found) begin
            dispatch_sel[i] = 1'b1;
            found           = 1'b1;
         end
      end
      dispatch_ok = (state == RUN) && (blocks_dispatched < total_blocks) && found;
      retire      = (state == RUN) ? (core_start & core_done) : '0;
      for (int i = 0; i < NUM_CORES; i++)
         retire_count = retire_count + {8'd0, retire[i]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         total_blocks      <= '0;
         remaining         <= '0;
         blocks_dispatched <= '0;
         blocks_done       <= '0;
         core_start        <= '0;
         core_reset        <= '1;
         core_block_id     <= '0;
         core_thread_count <= '0;
         done              <= 1'b0;
      end else begin
         done <= (state_next == DONE);
         if (state == IDLE && start) begin
            total_blocks      <= total_calc;
            remaining         <= {1'b0, thread_count};
            blocks_dispatched <= '0;
            blocks_done       <= '0;
         end
         if (state == RUN) begin
            if (state_next == DONE) begin
               core_start <= '0;
               core_reset <= '1;
            end else begin
               for (int i = 0; i < NUM_CORES; i++) begin
                  if (retire[i]) begin
                     core_start[i] <= 1'b0;
                     core_reset[i] <= 1'b1;
                  end
                  if (dispatch_ok && dispatch_sel[i]) begin
                     core_start[i]                      <= 1'b1;
                     core_reset[i]                      <= 1'b0;
                     core_block_id[8*i +: 8]            <= blocks_dispatched[7:0];
                     core_thread_count[TC_W*i +: TC_W]  <= blk_threads;
                  end
               end
               blocks_done <= blocks_done + retire_count;
               if (dispatch_ok) begin
                  blocks_dispatched <= blocks_dispatched + 9'd1;
                  remaining         <= remaining - 9'(blk_threads);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_block_dispatcher.sv
// tb/tb_block_dispatcher.sv - directed self-checking bench for block_dispatcher.
module tb_block_dispatcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] thread_count;
   logic [1:0] core_done;
   logic [1:0] core_start;
   logic [1:0] core_reset;
   logic [15:0] core_block_id;
   logic [5:0] core_thread_count;
   logic       done;

   int checks = 0;
   int errors = 0;

   // Dispatch/done activity seen on the outputs, sampled just after each rising edge.
   int         disp_total = 0;
   int         done_rises = 0;
   logic [1:0] prev_start = 2'b00;
   logic       prev_done  = 1'b0;
   logic [7:0] last_id [2];
   logic [2:0] last_cnt [2];

   block_dispatcher dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .thread_count      (thread_count),
      .core_done         (core_done),
      .core_start        (core_start),
      .core_reset        (core_reset),
      .core_block_id     (core_block_id),
      .core_thread_count (core_thread_count),
      .done              (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      for (int i = 0; i < 2; i++) begin
         if (core_start[i] && !prev_start[i]) begin
            disp_total++;
            last_id[i]  = core_block_id[8*i +: 8];
            last_cnt[i] = core_thread_count[3*i +: 3];
         end
      end
      if (done && !prev_done) done_rises++;
      prev_start = core_start;
      prev_done  = done;
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset        = 1'b1;
      start        = 1'($urandom);
      thread_count = 8'($urandom);
      core_done    = 2'($urandom);
      tick();
      tick();
      checks++; if (core_reset !== 2'b11) begin errors++; $display("FAIL reset_core_reset got %b exp 11", core_reset); end
      checks++; if (core_start !== 2'b00) begin errors++; $display("FAIL reset_core_start got %b exp 00", core_start); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (core_block_id !== 16'h0) begin errors++; $display("FAIL reset_block_id got %h exp 0000", core_block_id); end
      checks++; if (core_thread_count !== 6'h0) begin errors++; $display("FAIL reset_thread_count got %h exp 00", core_thread_count); end
      reset     = 1'b0;
      start     = 1'b0;
      core_done = 2'b00;
      tick();
   endtask

   task automatic test_even;
      start        = 1'b1;
      thread_count = 8'd8;
      tick();
      checks++; if (core_start !== 2'b00) begin errors++; $display("FAIL even_run_entry got %b exp 00", core_start); end
      tick();
      checks++; if (core_start !== 2'b01) begin errors++; $display("FAIL even_first_start got %b exp 01", core_start); end
      checks++; if (core_reset !== 2'b10) begin errors++; $display("FAIL even_first_reset got %b exp 10", core_reset); end
      checks++; if (core_block_id[7:0] !== 8'd0 || core_thread_count[2:0] !== 3'd4) begin
         errors++; $display("FAIL even_core0 got id %0d cnt %0d exp id 0 cnt 4", core_block_id[7:0], core_thread_count[2:0]);
      end
      tick();
      checks++; if (core_start !== 2'b11) begin errors++; $display("FAIL even_second_start got %b exp 11", core_start); end
      checks++; if (core_block_id[15:8] !== 8'd1 || core_thread_count[5:3] !== 3'd4) begin
         errors++; $display("FAIL even_core1 got id %0d cnt %0d exp id 1 cnt 4", core_block_id[15:8], core_thread_count[5:3]);
      end
      core_done = 2'b11;
      tick();
      core_done = 2'b00;
      checks++; if (core_start !== 2'b00 || core_reset !== 2'b11 || done !== 1'b0) begin
         errors++; $display("FAIL even_retire got start %b reset %b done %b exp 00 11 0", core_start, core_reset, done);
      end
      tick();
      checks++; if (done !== 1'b1 || core_reset !== 2'b11) begin
         errors++; $display("FAIL even_done got done %b reset %b exp 1 11", done, core_reset);
      end
      start = 1'b0;
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL even_done_clear got %b exp 0", done); end
      tick();
   endtask

   task automatic test_partial;
      int d0;
      d0           = disp_total;
      start        = 1'b1;
      thread_count = 8'd10;
      tick();
      tick();
      tick();
      checks++; if (core_start !== 2'b11 || core_block_id !== 16'h0100 || core_thread_count !== 6'o44) begin
         errors++; $display("FAIL partial_first_pair got start %b id %h cnt %o exp 11 0100 44", core_start, core_block_id, core_thread_count);
      end
      core_done = 2'b01;
      tick();
      core_done = 2'b00;
      checks++; if (core_reset !== 2'b01 || core_start !== 2'b10) begin
         errors++; $display("FAIL partial_retire0 got reset %b start %b exp 01 10", core_reset, core_start);
      end
      tick();
      checks++; if (core_start !== 2'b11 || core_block_id[7:0] !== 8'd2 || core_thread_count[2:0] !== 3'd2) begin
         errors++; $display("FAIL partial_redispatch got start %b id %0d cnt %0d exp 11 2 2", core_start, core_block_id[7:0], core_thread_count[2:0]);
      end
      core_done = 2'b11;
      tick();
      core_done = 2'b00;
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL partial_done got %b exp 1", done); end
      checks++; if (disp_total - d0 !== 3) begin errors++; $display("FAIL partial_dispatch_count got %0d exp 3", disp_total - d0); end
      start = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_zero;
      int d0;
      d0           = disp_total;
      start        = 1'b1;
      thread_count = 8'd0;
      tick();
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
      checks++; if (disp_total !== d0 || core_start !== 2'b00) begin
         errors++; $display("FAIL zero_no_start got %0d dispatches start %b exp 0 00", disp_total - d0, core_start);
      end
      start = 1'b0;
      tick();
      checks++; if (done !== 1'b0 || core_reset !== 2'b11) begin
         errors++; $display("FAIL zero_idle got done %b reset %b exp 0 11", done, core_reset);
      end
      tick();
   endtask

   task automatic test_full;
      int d0, r0, rounds, cyc;
      d0           = disp_total;
      r0           = done_rises;
      rounds       = 0;
      cyc          = 0;
      start        = 1'b1;
      thread_count = 8'd255;
      while (done !== 1'b1 && cyc < 2000) begin
         tick();
         cyc++;
         if (core_start == 2'b11 && core_done == 2'b00) begin
            core_done = 2'b11;
            rounds++;
         end else begin
            core_done = 2'b00;
         end
      end
      core_done = 2'b00;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_timeout got done %b exp 1 within 2000 cycles", done); end
      checks++; if (disp_total - d0 !== 64) begin errors++; $display("FAIL full_dispatch_count got %0d exp 64", disp_total - d0); end
      checks++; if (rounds !== 32) begin errors++; $display("FAIL full_pair_rounds got %0d exp 32", rounds); end
      checks++; if (last_id[1] !== 8'd63 || last_cnt[1] !== 3'd3) begin
         errors++; $display("FAIL full_last_block got id %0d cnt %0d exp 63 3", last_id[1], last_cnt[1]);
      end
      checks++; if (last_id[0] !== 8'd62 || last_cnt[0] !== 3'd4) begin
         errors++; $display("FAIL full_penultimate got id %0d cnt %0d exp 62 4", last_id[0], last_cnt[0]);
      end
      tick();
      tick();
      tick();
      checks++; if (done_rises - r0 !== 1 || done !== 1'b1) begin
         errors++; $display("FAIL full_done_once got rises %0d done %b exp 1 1", done_rises - r0, done);
      end
      start = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_mid_reset;
      start        = 1'b1;
      thread_count = 8'd20;
      tick();
      tick();
      tick();
      checks++; if (core_start !== 2'b11) begin errors++; $display("FAIL midrst_running got %b exp 11", core_start); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (core_start !== 2'b00 || core_reset !== 2'b11 || done !== 1'b0 ||
                    core_block_id !== 16'h0 || core_thread_count !== 6'h0) begin
         errors++; $display("FAIL midrst_values got start %b reset %b done %b id %h cnt %h exp 00 11 0 0000 00",
                            core_start, core_reset, done, core_block_id, core_thread_count);
      end
      tick();
      tick();
      checks++; if (core_start !== 2'b01 || core_block_id[7:0] !== 8'd0 || core_thread_count[2:0] !== 3'd4) begin
         errors++; $display("FAIL midrst_restart got start %b id %0d cnt %0d exp 01 0 4", core_start, core_block_id[7:0], core_thread_count[2:0]);
      end
      reset = 1'b1;
      start = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      thread_count = 8'd0;
      core_done    = 2'b00;
      test_reset();
      test_even();
      test_partial();
      test_zero();
      test_full();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
